// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t    : FSM state encoding (IDLE, ADD, SHIFT, HOLD)
//   WIDTH      : operand width in bits
//   ITERATIONS : number of ADD/SHIFT pairs per multiplication
// The optional signed mode is selected with the macro MULT_SIGNED_EN
// (consumed in shift_add_mult.sv).
package mult_pkg;

  localparam int WIDTH      = 8;
  localparam int ITERATIONS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/add_sub9.sv
// 9-bit combinational adder/subtractor used by the multiplier's ADD step.
// Ports:
//   a   [8:0] : minuend / first addend ({X,A})
//   b   [8:0] : subtrahend / second addend (extended multiplicand)
//   sub       : 1 -> a - b, 0 -> a + b
//   sum [8:0] : result, truncated to 9 bits (bit 8 is the carry in
//               unsigned mode and the sign in signed mode)
module add_sub9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       sub,
  output logic [8:0] sum
);

  // Two's-complement subtract: a + ~b + 1.
  logic [8:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {8'd0, sub};

endmodule

// File: rtl/shift_add_mult.sv
// Sequential 8x8 shift-and-add multiplier with a 16-bit result in {Aval,Bval}.
// Configuration macro: MULT_SIGNED_EN
//   defined   -> two's-complement operands, sign-extended multiplicand,
//                subtract on the 8th ADD, arithmetic shift through X
//   undefined -> unsigned operands, zero-extended multiplicand, X holds the
//                carry, shift inserts 0 above X
// Ports:
//   Clk          : clock, all state changes on rising edge
//   Reset        : asynchronous active-high reset
//   Run          : level start request
//   ClearA_LoadB : in IDLE, clear A/X and load B from Switches
//   Switches[7:0]: multiplicand (latched at start) or B load value
//   Aval[7:0]    : accumulator A, product high byte
//   Bval[7:0]    : multiplier/shift register B, product low byte
//   X            : extension bit above A
//   Done         : result valid and held
//   dbg_state[1:0]: current FSM state (mult_pkg::state_t encoding)
//
// Handshake: Run is a level request sampled in IDLE. Once accepted, Run and
// ClearA_LoadB are ignored until the result is held in HOLD with Done=1.
// The result stays frozen while Run remains high; dropping Run returns the
// block to IDLE and clears Done on that same edge. Holding Run high through
// HOLD never starts a second operation.
module shift_add_mult
  import mult_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] Switches,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X,
  output logic       Done,
  output logic [1:0] dbg_state
);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             x_q;
  logic [2:0]       cnt_q;
  logic             done_q;

  logic [8:0]       s_ext;
  logic             sub_en;
  logic             shift_fill;
  logic [8:0]       sum;

`ifdef MULT_SIGNED_EN
  // The last partial product carries negative weight in two's complement.
  assign s_ext      = {s_q[WIDTH-1], s_q};
  assign sub_en     = (cnt_q == 3'(ITERATIONS - 1));
  assign shift_fill = x_q;
`else
  assign s_ext      = {1'b0, s_q};
  assign sub_en     = 1'b0;
  assign shift_fill = 1'b0;
`endif

  add_sub9 u_add_sub9 (
    .a   ({x_q, a_q}),
    .b   (s_ext),
    .sub (sub_en),
    .sum (sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Run wins over ClearA_LoadB so B keeps the multiplier value.
          if (Run) begin
            a_q     <= '0;
            x_q     <= 1'b0;
            s_q     <= Switches;
            cnt_q   <= '0;
            state_q <= ST_ADD;
          end else if (ClearA_LoadB) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= Switches;
          end
        end
        ST_ADD: begin
          if (b_q[0]) begin
            {x_q, a_q} <= sum;
          end
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          x_q     <= shift_fill;
          a_q     <= {x_q, a_q[WIDTH-1:1]};
          b_q     <= {a_q[0], b_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + 3'd1;
          state_q <= (cnt_q == 3'(ITERATIONS - 1)) ? ST_HOLD : ST_ADD;
        end
        ST_HOLD: begin
          // Done is raised on the first HOLD edge; leaving HOLD is only
          // possible once Done has been visible for at least one cycle.
          if (!done_q) begin
            done_q <= 1'b1;
          end else if (!Run) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Aval      = a_q;
  assign Bval      = b_q;
  assign X         = x_q;
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Switches;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Done;
  logic [1:0] dbg_state;

  always #5 Clk = ~Clk;

  shift_add_mult dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Switches     (Switches),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Done         (Done),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic product of the two operands.
  function automatic logic [15:0] model_prod(input logic [7:0] s, input logic [7:0] b);
    int p;
`ifdef MULT_SIGNED_EN
    int si;
    int bi;
    si = $signed(s);
    bi = $signed(b);
    p  = si * bi;
`else
    p = int'(s) * int'(b);
`endif
    return p[15:0];
  endfunction

  function automatic logic model_x(input logic [15:0] prod);
`ifdef MULT_SIGNED_EN
    return prod[15];
`else
    return 1'b0 & prod[0];
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_b(input logic [7:0] b);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Switches     = b;
    @(posedge Clk);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    check("load_b", {16'd0, Aval, Bval}, {16'd0, 8'd0, b});
    check("load_x", {31'd0, X}, 32'd0);
  endtask

  // One complete multiplication. noisy: scramble Run/ClearA_LoadB/Switches
  // while busy. hold: keep Run high up to 40 cycles after start.
  // both: assert ClearA_LoadB together with Run at start.
  task automatic run_op(input logic [7:0] s, input logic [7:0] b,
                        input bit noisy, input bit hold, input bit both);
    logic [15:0] exp;
    int          done_at;
    load_b(b);
    Switches     = s;
    Run          = 1'b1;
    ClearA_LoadB = both;
    exp_q.push_back(model_prod(s, b));
    @(posedge Clk);  // accepting edge
    done_at = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done && done_at == 0) done_at = k;
      if (noisy && k <= 15) begin
        Run          = 1'($urandom_range(0, 1));
        ClearA_LoadB = 1'($urandom_range(0, 1));
        Switches     = 8'($urandom_range(0, 255));
      end else begin
        Run          = hold;
        ClearA_LoadB = 1'b0;
      end
    end
    check("done_latency", done_at, 17);
    exp = exp_q.pop_front();
    check("product", {16'd0, Aval, Bval}, {16'd0, exp});
    check("x_bit", {31'd0, X}, {31'd0, model_x(exp)});
    if (hold) begin
      repeat (40 - 17) begin
        @(posedge Clk);
        @(negedge Clk);
      end
      check("hold_done", {31'd0, Done}, 32'd1);
      check("hold_state", {30'd0, dbg_state}, 32'(ST_HOLD));
      check("hold_product", {16'd0, Aval, Bval}, {16'd0, exp});
      Run = 1'b0;
    end
    @(posedge Clk);
    @(negedge Clk);
    check("done_fall", {31'd0, Done}, 32'd0);
    check("idle_state", {30'd0, dbg_state}, 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    Switches     = 8'd0;
    repeat (2) @(negedge Clk);
    check("rst_a", {24'd0, Aval}, 32'd0);
    check("rst_b", {24'd0, Bval}, 32'd0);
    check("rst_x", {31'd0, X}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'(ST_IDLE));
    Reset = 1'b0;

`ifdef MULT_SIGNED_EN
    run_op(8'h07, 8'hFB, 1'b0, 1'b0, 1'b0);
    check("vec_m35", {16'd0, Aval, Bval}, 32'h0000FFDD);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("vec_1", {16'd0, Aval, Bval}, 32'h00000001);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    check("vec_4000", {16'd0, Aval, Bval}, 32'h00004000);
`else
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("vec_fe01", {16'd0, Aval, Bval}, 32'h0000FE01);
`endif

    // Clear/load in IDLE after a non-zero result.
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Switches     = 8'h3C;
    @(posedge Clk);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    check("clr_a", {24'd0, Aval}, 32'd0);
    check("clr_b", {24'd0, Bval}, 32'h3C);
    check("clr_x", {31'd0, X}, 32'd0);

    // Run held high through HOLD, then a fresh operation.
    run_op(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0);
    run_op(8'h13, 8'h27, 1'b0, 1'b0, 1'b0);

    // Noise on inputs while busy.
    run_op(8'hA7, 8'h6D, 1'b1, 1'b0, 1'b0);

    // Run and ClearA_LoadB together: B must not be reloaded.
    run_op(8'h0B, 8'hE6, 1'b0, 1'b0, 1'b1);

    // Reset mid-run.
    load_b(8'h99);
    Switches = 8'h77;
    Run      = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Run = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("mid_rst_a", {24'd0, Aval}, 32'd0);
    check("mid_rst_b", {24'd0, Bval}, 32'd0);
    check("mid_rst_x", {31'd0, X}, 32'd0);
    check("mid_rst_done", {31'd0, Done}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'(ST_IDLE));
    @(negedge Clk);
    Reset = 1'b0;
    run_op(8'h77, 8'h99, 1'b0, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end by 200000");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Run  input  1  level start request; sampled on posedge Clk.
REQ-004 ClearA_LoadB  input  1  in IDLE: clear A and X, load B from Switches.
REQ-005 Switches  input  8  multiplicand S (latched at start) or B load value.
REQ-006 Aval  output  8  accumulator register A (product high byte).
REQ-007 Bval  output  8  multiplier/shift register B (product low byte).
REQ-008 X  output  1  extension bit above A.
REQ-009 Done  output  1  high while result is held valid.

Function
REQ-010 The module SHALL implement FSM states IDLE, ADD, SHIFT and HOLD, encoded as a package enum.
REQ-011 IDLE: Run=1 -> clear A and X, latch Switches into S, iteration counter=0, go to ADD; otherwise ClearA_LoadB=1 -> A=0, X=0, B=Switches.
REQ-012 Run has priority over ClearA_LoadB in IDLE.
REQ-013 ADD: if B[0]=1, {X,A} SHALL become {X,A} + ext(S) (9-bit); else unchanged; always go to SHIFT.
REQ-014 SHIFT: {X,A,B} SHALL shift right one bit as defined by REQ-024/025; counter increments; counter==7 before increment -> HOLD, else ADD.
REQ-015 Exactly 8 ADD/SHIFT pairs; Done SHALL rise on the 17th posedge after the posedge that accepted Run.
REQ-016 HOLD: Done=1, registers frozen; Run=0 -> IDLE (Done=0 next cycle); Run held high SHALL NOT restart.
REQ-017 Run and ClearA_LoadB SHALL be ignored in ADD/SHIFT; ClearA_LoadB ignored in HOLD.
REQ-018 Switches changes after start SHALL NOT affect the result (S latched).
REQ-019 Result SHALL be {Aval,Bval}: the 16-bit product of S and the B value at start.

Reset
REQ-020 Reset asserted SHALL immediately force state=IDLE, A=0, B=0, X=0, S=0, counter=0, Done=0.
REQ-021 Reset mid-operation SHALL abort; no partial result retained; next Run starts cleanly.
REQ-022 No output SHALL be X/undefined after the first Reset assertion.

Configuration
REQ-023 Macro MULT_SIGNED_EN selects signed arithmetic.
REQ-024 Defined: two's-complement operands; ext(S) = sign extension; 8th ADD subtracts ({X,A} - ext(S)) when B[0]=1; shift is arithmetic (X replicated).
REQ-025 Undefined: unsigned operands; ext(S) = zero extension; X = 9th sum bit (carry); shift inserts 0 above X; no subtract step.
REQ-026 Cycle timing and interface SHALL be identical in both configurations.

Structure
REQ-027 Package mult_pkg SHALL hold the state enum, WIDTH=8, ITERATIONS=8.
REQ-028 One sub-module add_sub9 (9-bit adder with subtract control, combinational) SHALL perform the ADD step; FSM and registers reside in shift_add_mult.

Verification
REQ-029 Reset mid-run (after 5 cycles) -> all outputs 0 same cycle, state IDLE; later Run completes correctly.
REQ-030 Unsigned build: load B=0xFF, S=0xFF, Run -> Done at cycle 17, {A,B}=0xFE01, X=0.
REQ-031 Signed build: B=0xFB (-5), S=0x07, Run -> {A,B}=0xFFDD (-35); B=0xFF, S=0xFF -> 0x0001; B=0x80, S=0x80 -> 0x4000.
REQ-032 Run held high 40 cycles -> exactly one operation, Done stays 1; Run low -> Done 0 next cycle; Run high again -> new operation.
REQ-033 ClearA_LoadB and Switches toggled during ADD/SHIFT -> result unchanged; ClearA_LoadB in IDLE with Switches=0x3C -> B=0x3C, A=0, X=0 next cycle.
REQ-034 Run and ClearA_LoadB high together in IDLE -> operation starts, B not reloaded.
